// File: rtl/div_seq.sv
// Multi-cycle unsigned restoring divider. Each clock retires one quotient bit.
// Each trial subtraction is done as an add, R + ~D + 1, and its carry-out is the no-borrow flag.
//
// state | meaning
// IDLE  | waiting for start; busy=0
// RUN   | one restoring iteration per edge, WIDTH iterations in total
// DONE  | ready pulse for one cycle; results are valid
module div_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             ready,
  output logic             busy,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   r_sh;
  logic [WIDTH+1:0] sum;
  logic             no_borrow;
  logic [WIDTH:0]   r_next;
  logic [WIDTH-1:0] q_next;

  always_comb begin
    r_sh      = {r[WIDTH-1:0], q[WIDTH-1]};
    sum       = {1'b0, r_sh} + {1'b0, ~{1'b0, d}} + {{(WIDTH+1){1'b0}}, 1'b1};
    // r[WIDTH] is zero whenever the partial remainder has been restored below D.
    // If it were ever set, the shifted value would exceed D, so it forces no-borrow.
    no_borrow = sum[WIDTH+1] | r[WIDTH];
    r_next    = no_borrow ? sum[WIDTH:0] : r_sh;
    q_next    = {q[WIDTH-2:0], no_borrow};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      r           <= '0;
      q           <= '0;
      d           <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      ready       <= 1'b0;
      busy        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              ready       <= 1'b1;
              state       <= DONE;
            end else begin
              d           <= divisor;
              q           <= dividend;
              r           <= '0;
              count       <= '0;
              div_by_zero <= 1'b0;
              state       <= RUN;
            end
          end
        end
        RUN: begin
          r     <= r_next;
          q     <= q_next;
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) begin
            // Results are registered on the final iteration, so they are valid in the same cycle as ready.
            quotient  <= q_next;
            remainder <= r_next[WIDTH-1:0];
            ready     <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          ready <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ready <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed and randomized bench for div_seq (WIDTH=8).
// Inputs are driven on the falling edge, and outputs are sampled there as well.
module tb_div_seq;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       ready;
  logic       busy;
  logic       div_by_zero;

  int checks = 0;
  int passed = 0;

  div_seq #(.WIDTH(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .ready      (ready),
    .busy       (busy),
    .div_by_zero(div_by_zero)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", passed, checks);
    $fatal(1, "watchdog");
  end

  // Starts one division and waits, within a bounded number of cycles, for ready.
  // n is the number of rising edges counted from and including the edge that sampled start.
  task automatic run_div(input logic [7:0] a, input logic [7:0] b, output int n,
                         output logic [7:0] qv, output logic [7:0] rv, output logic dz,
                         output logic rdy, output logic busy1, output logic dz1,
                         output logic [7:0] q1);
    @(negedge clock);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clock);
    n = 1;
    @(negedge clock);
    start = 1'b0; dividend = ~a; divisor = ~b;
    busy1 = busy; dz1 = div_by_zero; q1 = quotient;
    while (!ready && n < 40) begin
      @(posedge clock);
      n++;
      @(negedge clock);
    end
    rdy = ready; qv = quotient; rv = remainder; dz = div_by_zero;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; dividend = 8'd0; divisor = 8'd0;
    repeat (2) @(negedge clock);
    checks++;
    if ({quotient, remainder, ready, busy, div_by_zero} !== 19'd0)
      $display("FAIL reset_state: got q=%0d r=%0d rdy=%b busy=%b dz=%b, want all 0",
               quotient, remainder, ready, busy, div_by_zero);
    else passed++;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int n; logic [7:0] qv, rv, q1; logic dz, rdy, busy1, dz1;
    run_div(8'd200, 8'd7, n, qv, rv, dz, rdy, busy1, dz1, q1);
    checks++;
    if (busy1 !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy1);
    else passed++;
    checks++;
    if (rdy !== 1'b1 || n != 9) $display("FAIL basic_latency: got ready=%b edges=%0d want ready=1 edges=9", rdy, n);
    else passed++;
    checks++;
    if (qv !== 8'd28 || rv !== 8'd4 || dz !== 1'b0)
      $display("FAIL basic_result: got %0d r %0d dz=%b want 28 r 4 dz=0", qv, rv, dz);
    else passed++;
    @(posedge clock); @(negedge clock);
    checks++;
    if (busy !== 1'b0 || ready !== 1'b0) $display("FAIL basic_after: got busy=%b ready=%b want 0 0", busy, ready);
    else passed++;
  endtask

  task automatic test_boundaries();
    logic [7:0] va [4] = '{8'd255, 8'd5, 8'd255, 8'd0};
    logic [7:0] vb [4] = '{8'd1,   8'd9, 8'd255, 8'd3};
    logic [7:0] vq [4] = '{8'd255, 8'd0, 8'd1,   8'd0};
    logic [7:0] vr [4] = '{8'd0,   8'd5, 8'd0,   8'd0};
    for (int i = 0; i < 4; i++) begin
      int n; logic [7:0] qv, rv, q1; logic dz, rdy, busy1, dz1;
      run_div(va[i], vb[i], n, qv, rv, dz, rdy, busy1, dz1, q1);
      checks++;
      if (rdy !== 1'b1 || n != 9 || qv !== vq[i] || rv !== vr[i] || dz !== 1'b0)
        $display("FAIL boundary_%0d: got %0d r %0d dz=%b rdy=%b edges=%0d want %0d r %0d dz=0 rdy=1 edges=9",
                 i, qv, rv, dz, rdy, n, vq[i], vr[i]);
      else passed++;
      @(posedge clock); @(negedge clock);
      checks++;
      if (ready !== 1'b0) $display("FAIL boundary_pulse_%0d: got ready=%b want 0", i, ready);
      else passed++;
    end
  endtask

  task automatic test_div_zero();
    int n; logic [7:0] qv, rv, q1; logic dz, rdy, busy1, dz1;
    run_div(8'd100, 8'd0, n, qv, rv, dz, rdy, busy1, dz1, q1);
    checks++;
    if (rdy !== 1'b1 || n != 1 || dz !== 1'b1 || qv !== 8'd255 || rv !== 8'd100)
      $display("FAIL divzero: got %0d r %0d dz=%b rdy=%b edges=%0d want 255 r 100 dz=1 rdy=1 edges=1",
               qv, rv, dz, rdy, n);
    else passed++;
    run_div(8'd9, 8'd3, n, qv, rv, dz, rdy, busy1, dz1, q1);
    checks++;
    if (dz1 !== 1'b0) $display("FAIL divzero_clear: got dz=%b want 0", dz1);
    else passed++;
    checks++;
    if (q1 !== 8'd255) $display("FAIL divzero_hold: got quotient=%0d want 255", q1);
    else passed++;
    checks++;
    if (rdy !== 1'b1 || n != 9 || qv !== 8'd3 || rv !== 8'd0 || dz !== 1'b0)
      $display("FAIL divzero_next: got %0d r %0d dz=%b edges=%0d want 3 r 0 dz=0 edges=9", qv, rv, dz, n);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int n; logic [7:0] qv, rv, q1; logic dz, rdy, busy1, dz1;
    @(negedge clock);
    start = 1'b1; dividend = 8'd200; divisor = 8'd7;
    @(posedge clock);
    n = 1;
    while (n < 40) begin
      @(negedge clock);
      if (ready) break;
      start = (n >= 2 && n <= 5); dividend = 8'd50; divisor = 8'd5;
      @(posedge clock);
      n++;
    end
    start = 1'b0;
    checks++;
    if (ready !== 1'b1 || n != 9 || quotient !== 8'd28 || remainder !== 8'd4)
      $display("FAIL ignore_start: got %0d r %0d rdy=%b edges=%0d want 28 r 4 rdy=1 edges=9",
               quotient, remainder, ready, n);
    else passed++;
    run_div(8'd50, 8'd5, n, qv, rv, dz, rdy, busy1, dz1, q1);
    checks++;
    if (busy1 !== 1'b1 || q1 !== 8'd28) $display("FAIL b2b_accept: got busy=%b quotient=%0d want 1 28", busy1, q1);
    else passed++;
    checks++;
    if (rdy !== 1'b1 || n != 9 || qv !== 8'd10 || rv !== 8'd0)
      $display("FAIL b2b_result: got %0d r %0d edges=%0d want 10 r 0 edges=9", qv, rv, n);
    else passed++;
  endtask

  task automatic test_async_reset();
    int n; logic [7:0] qv, rv, q1; logic dz, rdy, busy1, dz1;
    logic saw;
    @(negedge clock);
    start = 1'b1; dividend = 8'd200; divisor = 8'd7;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({quotient, remainder, ready, busy, div_by_zero} !== 19'd0)
      $display("FAIL async_reset: got q=%0d r=%0d rdy=%b busy=%b dz=%b want all 0",
               quotient, remainder, ready, busy, div_by_zero);
    else passed++;
    saw = 1'b0;
    repeat (12) begin
      @(negedge clock);
      if (ready) saw = 1'b1;
    end
    checks++;
    if (saw !== 1'b0) $display("FAIL async_no_ready: got ready pulse=%b want 0", saw);
    else passed++;
    reset = 1'b0;
    run_div(8'd17, 8'd4, n, qv, rv, dz, rdy, busy1, dz1, q1);
    checks++;
    if (rdy !== 1'b1 || n != 9 || qv !== 8'd4 || rv !== 8'd1 || dz !== 1'b0)
      $display("FAIL async_after: got %0d r %0d dz=%b edges=%0d want 4 r 1 dz=0 edges=9", qv, rv, dz, n);
    else passed++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      int n; logic [7:0] qv, rv, q1; logic dz, rdy, busy1, dz1;
      logic [7:0] a, b, eq, er;
      logic       edz;
      int         elat;
      a = 8'($urandom_range(0, 255));
      b = (i % 40 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      if (b == 8'd0) begin
        eq = 8'hFF; er = a; edz = 1'b1; elat = 1;
      end else begin
        eq = a / b; er = a % b; edz = 1'b0; elat = 9;
      end
      run_div(a, b, n, qv, rv, dz, rdy, busy1, dz1, q1);
      checks++;
      if (rdy !== 1'b1 || n != elat || qv !== eq || rv !== er || dz !== edz)
        $display("FAIL random_%0d %0d/%0d: got %0d r %0d dz=%b edges=%0d want %0d r %0d dz=%b edges=%0d",
                 i, a, b, qv, rv, dz, n, eq, er, edz, elat);
      else passed++;
      if (b != 8'd0) begin
        checks++;
        if ((16'(qv) * 16'(b) + 16'(rv)) != 16'(a) || rv >= b)
          $display("FAIL invariant_%0d %0d/%0d: got %0d r %0d", i, a, b, qv, rv);
        else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_div_zero();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multi-cycle unsigned restoring divider; the arithmetic inverse of the datapath's multiply and add path.
- Retires one quotient bit per clock.
- Each trial subtraction is performed in adder form: R + ~D + 1, carry-out = no-borrow.
- Sits beside the ALU; the processor stalls on busy and captures results on ready.

Parameters:
WIDTH, 8, operand, quotient and remainder width in bits (>= 2)

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
start  input  1  request pulse; sampled only when busy=0
dividend  input  WIDTH  unsigned dividend, sampled with start
divisor  input  WIDTH  unsigned divisor, sampled with start
quotient  output  WIDTH  result quotient; valid when ready=1, held until the next accepted start
remainder  output  WIDTH  result remainder; valid when ready=1, held until the next accepted start
ready  output  1  single-cycle pulse marking completion
busy  output  1  high whenever state != IDLE
div_by_zero  output  1  error flag; set with ready when divisor was 0, held until the next accepted start

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE; counter=0.
  - quotient, remainder, ready, busy and div_by_zero all 0.
  - Internal R/Q/D registers all 0.
- States:
  - IDLE: busy=0, ready=0.
    - start=1 with divisor!=0: latch D=divisor, Q=dividend, R=0 (WIDTH+1 bits), counter=0, clear div_by_zero, go to RUN.
    - start=1 with divisor==0: go directly to DONE with div_by_zero=1, quotient=all ones, remainder=dividend.
  - RUN: busy=1. Each edge performs one iteration:
    - {R,Q} shifted left 1; T = R_shifted + ~{0,D} + 1 (WIDTH+1 bits).
    - If the carry-out of T is 1: R=T and Q[0]=1. Otherwise R is kept and Q[0]=0.
    - counter increments; after the WIDTH-th iteration go to DONE.
  - DONE: busy=1 and ready=1 for exactly one cycle.
    - quotient=Q, remainder=R[WIDTH-1:0] (unless div_by_zero).
    - Next edge: go to IDLE unconditionally.
- Latency:
  - Nonzero divisor: ready is high in the cycle after the (WIDTH+1)-th rising edge counted from, and including, the edge that sampled start. For WIDTH=8 that is 9 edges.
  - Zero divisor: ready is high after 1 edge.
- Throughput: a new start is accepted in the IDLE cycle right after DONE. Back-to-back period is WIDTH+2 cycles.
- start while busy=1 (RUN or DONE): ignored; operands are not resampled.
- Operand changes after start is accepted have no effect.
- Outputs hold their last values from DONE until the next accepted start. The accepted start clears div_by_zero only; quotient and remainder keep their old values until the new DONE.
- Reset asserted mid-RUN: abort immediately to the reset values; no ready pulse.
- Edge cases (no special-case logic needed):
  - dividend < divisor gives quotient=0, remainder=dividend.
  - divisor=1 gives quotient=dividend, remainder=0.
  - Max operands: 255/255 gives quotient=1, remainder=0.
- Invariant on every non-error completion: quotient*divisor + remainder == dividend, and remainder < divisor.

Test Plan:
- Reset, then start with 200/7 → busy=1 from the next cycle; ready pulses 9 edges after start with quotient=28, remainder=4, div_by_zero=0; busy=0 the following cycle.
- Boundary operands, one at a time: 255/1 → 255 r 0; 5/9 → 0 r 5; 255/255 → 1 r 0; 0/3 → 0 r 0. Each ready pulse is exactly 1 cycle wide.
- 100/0 → ready after 1 edge with div_by_zero=1, quotient=255, remainder=100. A following 9/3 → div_by_zero=0 from the start edge; result 3 r 0.
- 200/7 started, then start=1 with 50/5 on edges 3–6 → ignored; result is still 28 r 4. Start 50/5 on the IDLE cycle after DONE → 10 r 0.
- Reset asserted asynchronously mid-RUN (between edges, during iteration 4) → outputs and busy clear immediately, no ready pulse. After release, 17/4 → 4 r 1.
- Randomized sweep of 2000 operand pairs, WIDTH=8, including divisor=0 → every result matches the reference model and the invariant above.
